sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_pkg.sv | 16 +
 rtl/rr_pick2.sv | 18 +
 rtl/sram_arbiter.sv | 108 ++++++++++
 tb/tb_sram_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the two-requester SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 8;

  // IDLE arbitrates, ACCESS drives the SRAM for one cycle, DONE reports completion.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to i_ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  output logic o_winner,
  output logic o_valid
);

  // Winner is 1 when only requester 1 asks, or on a tie when the pointer favours it.
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = (i_req0 & i_req1) ? i_ptr : i_req1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one single-port SRAM, one access per 3 cycles.
// Latency: req sampled in IDLE at edge N -> gnt N+1, chip select N+1..N+2, done/rdata N+2..N+3.
// Backpressure: requesters hold req until their done pulse; requests are only sampled in IDLE.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memDataIn,
  output logic              memWriteEnable,
  output logic              memChipSelect,
  input  logic [DATA_W-1:0] memDataOut
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ptr;
  logic               r_owner;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               w_winner;
  logic               w_valid;
  logic               w_grant;
  logic               w_busy;

  rr_pick2 u_pick (
    .i_req0   (req0),
    .i_req1   (req1),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // A grant is taken only from IDLE; requests are ignored while busy.
  assign w_grant = (r_state == ST_IDLE) && w_valid;

  // Next-state: fixed IDLE -> ACCESS -> DONE -> IDLE walk once granted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_valid) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Latch the winning request and hand priority to the loser on every grant.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_ptr   <= ~w_winner;
      r_owner <= w_winner;
      r_we    <= w_winner ? we1    : we0;
      r_addr  <= w_winner ? addr1  : addr0;
      r_wdata <= w_winner ? wdata1 : wdata0;
    end
  end

  // Capture SRAM read data at the end of a read ACCESS; writes leave rdata untouched.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                              r_rdata <= '0;
    else if (r_state == ST_ACCESS && !r_we)   r_rdata <= memDataOut;
  end

  // Grant covers ACCESS and DONE; done and chip select are decoded from state.
  assign w_busy         = (r_state != ST_IDLE);
  assign gnt0           = w_busy & ~r_owner;
  assign gnt1           = w_busy &  r_owner;
  assign done0          = (r_state == ST_DONE) & ~r_owner;
  assign done1          = (r_state == ST_DONE) &  r_owner;
  assign memChipSelect  = (r_state == ST_ACCESS);
  assign memWriteEnable = (r_state == ST_ACCESS) & r_we;
  assign memAddress     = r_addr;
  assign memDataIn      = r_wdata;
  assign rdata          = r_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural 8x8 SRAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [2:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata;
  logic [2:0] memAddress;
  logic [7:0] memDataIn;
  logic       memWriteEnable, memChipSelect;
  logic [7:0] memDataOut;

  logic [7:0] mem [8];

  typedef struct {
    logic       owner;
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;   // write data for the access, expected rdata for the done
  } exp_t;

  exp_t exp_acc[$];
  exp_t exp_done[$];
  exp_t e_acc, e_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  bit have_prev = 0;
  bit spacing_on = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .resetN(resetN),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata),
    .memAddress(memAddress), .memDataIn(memDataIn),
    .memWriteEnable(memWriteEnable), .memChipSelect(memChipSelect),
    .memDataOut(memDataOut)
  );

  // Behavioural SRAM: synchronous write, combinational read while selected.
  always @(posedge clk) if (memChipSelect && memWriteEnable) mem[memAddress] <= memDataIn;
  assign memDataOut = (memChipSelect && !memWriteEnable) ? mem[memAddress] : 8'h00;

  // Monitor: compares every SRAM access and every done pulse against the queues.
  always @(negedge clk) begin
    cyc++;
    if (!spacing_on) have_prev = 0;
    if (memChipSelect) begin
      checks++;
      if (exp_acc.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access addr=%0d we=%0b gnt=%b%b", memAddress, memWriteEnable, gnt1, gnt0);
      end else begin
        e_acc = exp_acc.pop_front();
        if (memAddress !== e_acc.addr || memWriteEnable !== e_acc.we ||
            (e_acc.we && memDataIn !== e_acc.data) ||
            gnt0 !== ~e_acc.owner || gnt1 !== e_acc.owner) begin
          errors++;
          $display("FAIL access got addr=%0d we=%0b din=%h gnt=%b%b want addr=%0d we=%0b din=%h owner=%0d",
                   memAddress, memWriteEnable, memDataIn, gnt1, gnt0,
                   e_acc.addr, e_acc.we, e_acc.data, e_acc.owner);
        end
      end
    end else if (gnt0 || gnt1) begin
      checks++;
      if (memWriteEnable !== 1'b0) begin
        errors++;
        $display("FAIL we_outside_access got=%0b want=0", memWriteEnable);
      end
    end
    if (done0 || done1) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done done=%b%b", done1, done0);
      end else begin
        e_done = exp_done.pop_front();
        if (done0 !== ~e_done.owner || done1 !== e_done.owner ||
            gnt0 !== ~e_done.owner || gnt1 !== e_done.owner || rdata !== e_done.data) begin
          errors++;
          $display("FAIL done got done=%b%b gnt=%b%b rdata=%h want owner=%0d rdata=%h",
                   done1, done0, gnt1, gnt0, rdata, e_done.owner, e_done.data);
        end
      end
      if (spacing_on) begin
        if (have_prev) begin
          checks++;
          if (cyc - last_done != 3) begin
            errors++;
            $display("FAIL done_spacing got=%0d want=3", cyc - last_done);
          end
        end
        have_prev = 1;
        last_done = cyc;
      end
    end
    if (gnt0 || gnt1) begin
      checks++;
      if (gnt0 && gnt1) begin
        errors++;
        $display("FAIL gnt_overlap got=%b%b want one-hot", gnt1, gnt0);
      end
    end
  end

  task automatic push(input logic owner, input logic we, input logic [2:0] addr,
                      input logic [7:0] wdata, input logic [7:0] exp_rd);
    exp_t a;
    exp_t d;
    a.owner = owner; a.we = we; a.addr = addr; a.data = wdata;
    d.owner = owner; d.we = we; d.addr = addr; d.data = exp_rd;
    exp_acc.push_back(a);
    exp_done.push_back(d);
  endtask

  task automatic wait_done(input int n);
    int seen = 0;
    int c = 0;
    while (seen < n && c < 40) begin
      @(negedge clk);
      c++;
      if (done0 || done1) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got=%0d want=%0d", seen, n);
    end
  endtask

  task automatic set_req(input logic owner, input logic we, input logic [2:0] addr,
                         input logic [7:0] wdata);
    if (owner) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else       begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
  endtask

  task automatic single(input logic owner, input logic we, input logic [2:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd);
    push(owner, we, addr, wdata, exp_rd);
    @(posedge clk); #1;
    set_req(owner, we, addr, wdata);
    wait_done(1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},  {6'd0, gnt1, gnt0}, 8'h00);
    chk({tag, "_done"}, {6'd0, done1, done0}, 8'h00);
    chk({tag, "_ctl"},  {6'd0, memChipSelect, memWriteEnable}, 8'h00);
    chk({tag, "_addr"}, {5'd0, memAddress}, 8'h00);
    chk({tag, "_din"},  memDataIn, 8'h00);
    chk({tag, "_rdata"}, rdata, 8'h00);
  endtask

  initial begin
    #2;
    chk_reset_outputs("reset");
    @(negedge clk); resetN = 1'b1;

    // Single write then read-back by the other requester.
    single(1'b0, 1'b1, 3'd3, 8'hA5, 8'h00);
    single(1'b1, 1'b0, 3'd3, 8'h00, 8'hA5);

    // Contention: both held, pointer is back at 0 -> grants 0,1,0,1.
    push(1'b0, 1'b1, 3'd1, 8'h11, 8'hA5);
    push(1'b1, 1'b1, 3'd2, 8'h22, 8'hA5);
    push(1'b0, 1'b1, 3'd1, 8'h11, 8'hA5);
    push(1'b1, 1'b1, 3'd2, 8'h22, 8'hA5);
    @(posedge clk); #1;
    spacing_on = 1;
    set_req(1'b0, 1'b1, 3'd1, 8'h11);
    set_req(1'b1, 1'b1, 3'd2, 8'h22);
    wait_done(4);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; spacing_on = 0;
    single(1'b0, 1'b0, 3'd2, 8'h00, 8'h22);
    single(1'b1, 1'b0, 3'd1, 8'h00, 8'h11);

    // Reset during ACCESS: the write to word 5 must be lost with no done.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'd5, 8'h5A);
    set_req(1'b1, 1'b0, 3'd5, 8'h00);
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    push(1'b0, 1'b1, 3'd5, 8'h5A, 8'h00);
    push(1'b1, 1'b0, 3'd5, 8'h00, 8'h5A);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    wait_done(2);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;

    // Early drop: req0 falls the cycle after grant; the access still completes once.
    push(1'b0, 1'b1, 3'd6, 8'h66, 8'h5A);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'd6, 8'h66);
    @(posedge clk); #1;
    req0 = 1'b0;
    wait_done(1);
    repeat (6) @(posedge clk);
    #1;
    chk("early_drop_gnt0", {7'd0, gnt0}, 8'h00);
    single(1'b1, 1'b0, 3'd6, 8'h00, 8'h66);

    repeat (3) @(posedge clk);
    #1;
    chk("acc_queue_left", exp_acc.size()[7:0], 8'h00);
    chk("done_queue_left", exp_done.size()[7:0], 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
